output_port_receiver: RTL

//  Receiving end of the MPU output-port interface. Captures every byte the MPU writes to its

---
 rtl/output_port_receiver.sv | 94 +++++++++
 1 files changed

// File: rtl/output_port_receiver.sv
// Receiving end of the MPU output port: buffers written bytes in a FIFO and presents them
// downstream over valid/ready, with a status byte the MPU polls before writing.
module output_port_receiver #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          inCLK,
    input  logic          inRST,
    input  logic          inLo,
    input  logic [7:0]    inData,
    input  logic          inClrOvf,
    output logic [7:0]    oTxData,
    output logic          oTxValid,
    input  logic          inTxReady,
    output logic [AW:0]   oCount,
    output logic          oReady,
    output logic          oOverflow,
    output logic [7:0]    oStatus
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t        state;
    state_t        stateNext;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   count;
    logic [7:0]    txData;
    logic          overflow;

    logic          full;
    logic          pop;
    logic          wrAccept;
    logic          wrDrop;

    // Pop/accept decisions and output-stage next state
    always_comb begin
        full      = (count == (AW+1)'(DEPTH));
        pop       = 1'b0;
        wrAccept  = 1'b0;
        wrDrop    = 1'b0;
        stateNext = state;

        pop      = (count != '0) && ((state == IDLE) || inTxReady);
        wrAccept = inLo && (!full || pop);
        wrDrop   = inLo && full && !pop;

        case (state)
            IDLE: if (pop) stateNext = HOLD;
            HOLD: if (inTxReady) stateNext = pop ? HOLD : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Storage has no reset; pointers alone define what is live
    always_ff @(posedge inCLK) begin
        if (wrAccept) mem[wp] <= inData;
    end

    always_ff @(posedge inCLK or negedge inRST) begin
        if (!inRST) begin
            state    <= IDLE;
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            txData   <= 8'h00;
            overflow <= 1'b0;
        end else begin
            state <= stateNext;
            if (wrAccept) wp <= wp + AW'(1);
            if (pop) begin
                rp     <= rp + AW'(1);
                txData <= mem[rp];
            end
            if (wrAccept && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !wrAccept) count <= count - (AW+1)'(1);
            // A dropped write on the same edge as a clear leaves the flag set
            if (wrDrop)        overflow <= 1'b1;
            else if (inClrOvf) overflow <= 1'b0;
        end
    end

    assign oTxValid  = (state == HOLD);
    assign oTxData   = txData;
    assign oCount    = count;
    assign oReady    = !full;
    assign oOverflow = overflow;
    assign oStatus   = {5'b0, overflow, oTxValid, !full};

endmodule
